// File: rtl/pipeline_command_sequencer_pkg.sv
// Shared opcodes, error codes, FSM states and field sizing
// for the pipeline command sequencer.
package pipeline_command_sequencer_pkg;

  localparam logic [3:0] OP_WR_INSTR  = 4'd1;
  localparam logic [3:0] OP_WR_REG    = 4'd2;
  localparam logic [3:0] OP_UPD_REG   = 4'd3;
  localparam logic [3:0] OP_COMMIT    = 4'd4;
  localparam logic [3:0] OP_ALLOC     = 4'd5;
  localparam logic [3:0] OP_SWAP      = 4'd6;
  localparam logic [3:0] OP_RESET     = 4'd7;
  localparam logic [3:0] OP_IN_GAIN   = 4'd8;
  localparam logic [3:0] OP_OUT_GAIN  = 4'd9;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OPCODE   = 3'd1;
  localparam logic [2:0] ERR_PIPE     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_SWAP     = 3'd4;

  typedef enum logic [3:0] {
    S_READY,
    S_DECODE,
    S_GET_BLOCK,
    S_GET_REG,
    S_GET_DATA,
    S_GET_INSTR,
    S_GET_DELAY,
    S_EXEC,
    S_SWAP_WAIT,
    S_SETTLE_WAIT
  } state_t;

  function automatic logic [3:0] field_bytes(input int width);
    return 4'(width / 8);
  endfunction

endpackage

// File: rtl/pipeline_command_sequencer_watchdog.sv
// Stall watchdog: counts cycles since the last clear and flags
// expiry at LIMIT; LIMIT of 0 disables it.
module pipeline_command_sequencer_watchdog #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  if (LIMIT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam logic [31:0] LAST = 32'(LIMIT - 1);
    logic [31:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (clear) begin
        cnt <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 32'd1;
      end
    end

    assign expire = (cnt == LAST);
  end

endmodule

// File: rtl/pipeline_command_sequencer.sv
// Byte-stream command decoder driving N DSP pipelines, with
// per-command addressing, active/standby swap and a watchdog.
module pipeline_command_sequencer
  import pipeline_command_sequencer_pkg::*;
#(
  parameter int N_BLOCKS       = 256,
  parameter int N_PIPELINES    = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int INSTR_WIDTH    = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int BW = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1,
  localparam int NP = N_PIPELINES,
  localparam int PW = $clog2(N_PIPELINES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_byte,
  input  logic                    in_ready,
  output logic                    next,
  output logic [BW-1:0]           block_target,
  output logic [REG_ADDR_WIDTH-1:0] reg_target,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [INSTR_WIDTH-1:0]  instr_out,
  output logic [2*DATA_WIDTH-1:0] buf_init_delay,
  output logic [NP-1:0]           block_instr_write,
  output logic [NP-1:0]           block_reg_write,
  output logic [NP-1:0]           block_reg_update,
  output logic [NP-1:0]           reg_writes_commit,
  output logic [NP-1:0]           alloc_delay,
  output logic [NP-1:0]           pipeline_reset,
  output logic [NP-1:0]           pipeline_enables,
  input  logic [NP-1:0]           pipeline_regfiles_syncing,
  input  logic [NP-1:0]           pipeline_resetting,
  output logic                    swap_pipelines,
  output logic [PW-1:0]           swap_target,
  input  logic                    pipelines_swapping,
  output logic [PW-1:0]           current_pipeline,
  output logic                    set_input_gain,
  output logic                    set_output_gain,
  output logic                    error_pulse,
  output logic [7:0]              status_out
);

  localparam logic [3:0] DATA_LAST  =
    field_bytes(DATA_WIDTH) - 4'd1;
  localparam logic [3:0] INSTR_LAST =
    field_bytes(INSTR_WIDTH) - 4'd1;
  localparam logic [3:0] DELAY_LAST =
    field_bytes(2 * DATA_WIDTH) - 4'd1;

  state_t        state, state_n;
  logic [3:0]    op, pipe, idx;
  logic [2:0]    err_code, err_n, fault;
  logic [PW-1:0] current;
  logic [NP-1:0] sel;
  logic          take, fresh, expire, pvalid;
  logic          hold, swap_done;

  assign take = in_ready && !next &&
    (state inside {S_READY, S_GET_BLOCK, S_GET_REG,
                   S_GET_DATA, S_GET_INSTR, S_GET_DELAY});
  assign pvalid = int'(pipe) < NP;
  assign sel = NP'(1) << pipe;
  assign hold = pipelines_swapping ||
    |(pipeline_regfiles_syncing & sel);

  assign swap_target = pipe[PW-1:0];
  assign current_pipeline = current;
  assign status_out =
    {err_code, state != S_READY, 4'(current)};

  pipeline_command_sequencer_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (take || (state_n != state)),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_READY;
    else       state <= state_n;
  end

  always_comb begin
    state_n           = state;
    err_n             = err_code;
    fault             = ERR_NONE;
    error_pulse       = 1'b0;
    block_instr_write = '0;
    block_reg_write   = '0;
    block_reg_update  = '0;
    reg_writes_commit = '0;
    alloc_delay       = '0;
    pipeline_reset    = '0;
    swap_pipelines    = 1'b0;
    set_input_gain    = 1'b0;
    set_output_gain   = 1'b0;
    swap_done         = 1'b0;
    unique case (state)
      S_READY: begin
        if (take) begin
          state_n = S_DECODE;
          err_n   = ERR_NONE;
        end
      end
      S_DECODE: begin
        state_n = S_READY;
        if (op inside {[OP_WR_INSTR:OP_RESET]} && !pvalid) begin
          fault = ERR_PIPE;
        end else begin
          case (op)
            OP_WR_INSTR, OP_WR_REG, OP_UPD_REG:
              state_n = S_GET_BLOCK;
            OP_ALLOC, OP_IN_GAIN, OP_OUT_GAIN:
              state_n = S_GET_DATA;
            OP_COMMIT: reg_writes_commit = sel;
            OP_RESET:  pipeline_reset = sel;
            OP_SWAP: begin
              if (pipe == 4'(current)) begin
                fault = ERR_SWAP;
              end else begin
                reg_writes_commit = sel;
                swap_pipelines    = 1'b1;
                state_n           = S_SWAP_WAIT;
              end
            end
            default: fault = ERR_OPCODE;
          endcase
        end
        if (fault != ERR_NONE) begin
          error_pulse = 1'b1;
          err_n       = fault;
        end
      end
      S_GET_BLOCK: begin
        if (take)
          state_n = (op == OP_WR_INSTR) ? S_GET_INSTR : S_GET_REG;
      end
      S_GET_REG: begin
        if (take) state_n = S_GET_DATA;
      end
      S_GET_DATA: begin
        if (take && idx == DATA_LAST)
          state_n = (op == OP_ALLOC) ? S_GET_DELAY : S_EXEC;
      end
      S_GET_INSTR: begin
        if (take && idx == INSTR_LAST) state_n = S_EXEC;
      end
      S_GET_DELAY: begin
        if (take && idx == DELAY_LAST) state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = S_READY;
        case (op)
          OP_WR_INSTR: block_instr_write = sel;
          OP_WR_REG: begin
            if (hold) state_n = S_EXEC;
            else      block_reg_write = sel;
          end
          OP_UPD_REG: begin
            if (hold) state_n = S_EXEC;
            else      block_reg_update = sel;
          end
          OP_ALLOC:    alloc_delay = sel;
          OP_IN_GAIN:  set_input_gain = 1'b1;
          OP_OUT_GAIN: set_output_gain = 1'b1;
          default: ;
        endcase
      end
      // first cycle of each wait state ignores its handshake input
      S_SWAP_WAIT: begin
        if (!fresh && !pipelines_swapping) begin
          swap_done = 1'b1;
          state_n   = S_SETTLE_WAIT;
        end
      end
      S_SETTLE_WAIT: begin
        if (!fresh && pipeline_resetting == '0) state_n = S_READY;
      end
      default: state_n = S_READY;
    endcase
    // any strobe or progress leaves the state, so it beats expiry
    if (expire && state != S_READY &&
        state_n == state && !take) begin
      state_n     = S_READY;
      err_n       = ERR_TIMEOUT;
      error_pulse = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next             <= 1'b0;
      fresh            <= 1'b0;
      err_code         <= ERR_NONE;
      idx              <= '0;
      op               <= '0;
      pipe             <= '0;
      current          <= '0;
      pipeline_enables <= NP'(1);
      block_target     <= '0;
      reg_target       <= '0;
      data_out         <= '0;
      instr_out        <= '0;
      buf_init_delay   <= '0;
    end else begin
      next     <= take;
      fresh    <= (state_n != state);
      err_code <= err_n;
      idx      <= (state_n != state) ? 4'd0 : idx + {3'd0, take};
      if (take) begin
        case (state)
          S_READY:     {op, pipe} <= in_byte;
          S_GET_BLOCK: block_target <= in_byte[BW-1:0];
          S_GET_REG:
            reg_target <= in_byte[REG_ADDR_WIDTH-1:0];
          S_GET_DATA:
            data_out <= (data_out << 8) | DATA_WIDTH'(in_byte);
          S_GET_INSTR:
            instr_out <= (instr_out << 8) | INSTR_WIDTH'(in_byte);
          S_GET_DELAY:
            buf_init_delay <= (buf_init_delay << 8) |
              (2 * DATA_WIDTH)'(in_byte);
          default: ;
        endcase
      end
      if (swap_pipelines)
        pipeline_enables <= pipeline_enables | sel;
      if (swap_done) begin
        pipeline_enables <=
          pipeline_enables & ~(NP'(1) << current);
        current <= pipe[PW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pipeline_command_sequencer.sv
// Directed bench: vector table for single commands plus hand
// sequences for regfile hold, swap, watchdog and mid-command reset.
module tb_pipeline_command_sequencer;

  localparam int K_INSTR = 0, K_WR = 1, K_UPD = 2, K_COMMIT = 3;
  localparam int K_ALLOC = 4, K_RESET = 5, K_ING = 6, K_OUTG = 7;
  localparam int K_ERR = 8, K_SWAP = 9;
  localparam int NV = 15;

  typedef struct {
    int          n;
    logic [55:0] b;
    int          kind;
    logic [3:0]  mask;
    logic [7:0]  blk;
    logic [3:0]  rg;
    logic [15:0] d;
    logic [31:0] ins;
    logic [31:0] dl;
    logic [2:0]  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready = 1'b0;
  logic [3:0]  syncing = 4'h0;
  logic [3:0]  resetting = 4'h0;
  logic        swapping = 1'b0;

  logic        next, swap_pipelines, set_input_gain;
  logic        set_output_gain, error_pulse;
  logic [7:0]  block_target, status_out;
  logic [3:0]  reg_target;
  logic [15:0] data_out;
  logic [31:0] instr_out, buf_init_delay;
  logic [3:0]  block_instr_write, block_reg_write;
  logic [3:0]  block_reg_update, reg_writes_commit;
  logic [3:0]  alloc_delay, pipeline_reset, pipeline_enables;
  logic [1:0]  swap_target, current_pipeline;

  int total = 0;
  int bad = 0;
  int scnt [10] = '{default: 0};
  logic [3:0] smask [10] = '{default: 4'h0};
  int base [10];
  vec_t vt [NV];

  pipeline_command_sequencer #(
    .N_BLOCKS(256), .N_PIPELINES(4), .DATA_WIDTH(16),
    .INSTR_WIDTH(32), .REG_ADDR_WIDTH(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset),
    .in_byte(in_byte), .in_ready(in_ready), .next(next),
    .block_target(block_target), .reg_target(reg_target),
    .data_out(data_out), .instr_out(instr_out),
    .buf_init_delay(buf_init_delay),
    .block_instr_write(block_instr_write),
    .block_reg_write(block_reg_write),
    .block_reg_update(block_reg_update),
    .reg_writes_commit(reg_writes_commit),
    .alloc_delay(alloc_delay), .pipeline_reset(pipeline_reset),
    .pipeline_enables(pipeline_enables),
    .pipeline_regfiles_syncing(syncing),
    .pipeline_resetting(resetting),
    .swap_pipelines(swap_pipelines), .swap_target(swap_target),
    .pipelines_swapping(swapping),
    .current_pipeline(current_pipeline),
    .set_input_gain(set_input_gain),
    .set_output_gain(set_output_gain),
    .error_pulse(error_pulse), .status_out(status_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (|block_instr_write) begin
      scnt[K_INSTR]++; smask[K_INSTR] = block_instr_write;
    end
    if (|block_reg_write) begin
      scnt[K_WR]++; smask[K_WR] = block_reg_write;
    end
    if (|block_reg_update) begin
      scnt[K_UPD]++; smask[K_UPD] = block_reg_update;
    end
    if (|reg_writes_commit) begin
      scnt[K_COMMIT]++; smask[K_COMMIT] = reg_writes_commit;
    end
    if (|alloc_delay) begin
      scnt[K_ALLOC]++; smask[K_ALLOC] = alloc_delay;
    end
    if (|pipeline_reset) begin
      scnt[K_RESET]++; smask[K_RESET] = pipeline_reset;
    end
    if (set_input_gain) scnt[K_ING]++;
    if (set_output_gain) scnt[K_OUTG]++;
    if (error_pulse) scnt[K_ERR]++;
    if (swap_pipelines) scnt[K_SWAP]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation ran away");
    $fatal(1, "timeout");
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 10; i++) base[i] = scnt[i];
  endtask

  function automatic int delta(input int k);
    return scnt[k] - base[k];
  endfunction

  function automatic int dsum();
    int s = 0;
    for (int i = 0; i < 9; i++) s += scnt[i] - base[i];
    return s;
  endfunction

  function automatic vec_t mk(
    input int n, input logic [55:0] b, input int kind,
    input logic [3:0] mask, input logic [7:0] blk,
    input logic [3:0] rg, input logic [15:0] d,
    input logic [31:0] ins, input logic [31:0] dl,
    input logic [2:0] e);
    vec_t v;
    v.n = n; v.b = b; v.kind = kind; v.mask = mask;
    v.blk = blk; v.rg = rg; v.d = d; v.ins = ins;
    v.dl = dl; v.e = e;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int w;
    @(posedge clk); #1;
    in_byte = b;
    in_ready = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!next && w < 50);
    in_ready = 1'b0;
    check($sformatf("handshake_%02h", b), 64'(next), 64'd1);
  endtask

  task automatic send_seq(input logic [55:0] b, input int n);
    for (int j = 0; j < n; j++) send_byte(b[55-8*j -: 8]);
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (status_out[4] && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check(name, 64'(status_out[4]), 64'd0);
  endtask

  initial begin
    int k;
    vt[0]  = mk(5, 56'h22_05_03_12_34_00_00, K_WR, 4'b0100,
                8'h05, 4'h3, 16'h1234, 0, 0, 3'd0);
    vt[1]  = mk(6, 56'h13_07_DE_AD_BE_EF_00, K_INSTR, 4'b1000,
                8'h07, 0, 0, 32'hDEADBEEF, 0, 3'd0);
    vt[2]  = mk(5, 56'h30_FF_0A_AB_CD_00_00, K_UPD, 4'b0001,
                8'hFF, 4'hA, 16'hABCD, 0, 0, 3'd0);
    vt[3]  = mk(1, 56'h41_00_00_00_00_00_00, K_COMMIT, 4'b0010,
                0, 0, 0, 0, 0, 3'd0);
    vt[4]  = mk(1, 56'h72_00_00_00_00_00_00, K_RESET, 4'b0100,
                0, 0, 0, 0, 0, 3'd0);
    vt[5]  = mk(3, 56'h80_12_34_00_00_00_00, K_ING, 4'b0000,
                0, 0, 16'h1234, 0, 0, 3'd0);
    vt[6]  = mk(3, 56'h9F_00_07_00_00_00_00, K_OUTG, 4'b0000,
                0, 0, 16'h0007, 0, 0, 3'd0);
    vt[7]  = mk(7, 56'h51_00_01_00_01_23_45, K_ALLOC, 4'b0010,
                0, 0, 16'h0001, 0, 32'h00012345, 3'd0);
    vt[8]  = mk(1, 56'h25_00_00_00_00_00_00, K_ERR, 0,
                0, 0, 0, 0, 0, 3'd2);
    vt[9]  = mk(1, 56'hF0_00_00_00_00_00_00, K_ERR, 0,
                0, 0, 0, 0, 0, 3'd1);
    vt[10] = mk(1, 56'h60_00_00_00_00_00_00, K_ERR, 0,
                0, 0, 0, 0, 0, 3'd4);
    vt[11] = mk(1, 56'h05_00_00_00_00_00_00, K_ERR, 0,
                0, 0, 0, 0, 0, 3'd1);
    vt[12] = mk(1, 56'hA3_00_00_00_00_00_00, K_ERR, 0,
                0, 0, 0, 0, 0, 3'd1);
    vt[13] = mk(1, 56'h74_00_00_00_00_00_00, K_ERR, 0,
                0, 0, 0, 0, 0, 3'd2);
    vt[14] = mk(1, 56'h43_00_00_00_00_00_00, K_COMMIT, 4'b1000,
                0, 0, 0, 0, 0, 3'd0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_next", 64'(next), 64'd0);
    check("rst_enables", 64'(pipeline_enables), 64'h1);
    check("rst_current", 64'(current_pipeline), 64'd0);
    check("rst_status", 64'(status_out), 64'd0);
    check("rst_fields",
          64'({block_target, reg_target, data_out}), 64'd0);
    check("rst_instr_delay",
          64'({instr_out, buf_init_delay}), 64'd0);
    check("rst_strobes",
          64'({block_instr_write, block_reg_write,
               block_reg_update, reg_writes_commit, alloc_delay,
               pipeline_reset, set_input_gain, set_output_gain,
               swap_pipelines, error_pulse}), 64'd0);

    for (int i = 0; i < NV; i++) begin
      snap();
      send_seq(vt[i].b, vt[i].n);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i),
            64'(delta(vt[i].kind)), 64'd1);
      check($sformatf("v%0d_total", i), 64'(dsum()), 64'd1);
      check($sformatf("v%0d_err", i),
            64'(status_out[7:4]), 64'({vt[i].e, 1'b0}));
      if (vt[i].kind <= K_RESET)
        check($sformatf("v%0d_mask", i),
              64'(smask[vt[i].kind]), 64'(vt[i].mask));
      if (vt[i].kind == K_WR || vt[i].kind == K_UPD)
        check($sformatf("v%0d_blk_reg_data", i),
              64'({block_target, reg_target, data_out}),
              64'({vt[i].blk, vt[i].rg, vt[i].d}));
      if (vt[i].kind == K_INSTR)
        check($sformatf("v%0d_blk_instr", i),
              64'({block_target, instr_out}),
              64'({vt[i].blk, vt[i].ins}));
      if (vt[i].kind == K_ALLOC)
        check($sformatf("v%0d_data_delay", i),
              64'({data_out, buf_init_delay}),
              64'({vt[i].d, vt[i].dl}));
      if (vt[i].kind == K_ING || vt[i].kind == K_OUTG)
        check($sformatf("v%0d_gain_data", i),
              64'(data_out), 64'(vt[i].d));
    end

    // register write held off by regfile sync on its own pipeline
    snap();
    syncing = 4'b0011;
    send_seq(56'h21_00_04_55_66_00_00, 5);
    repeat (20) @(posedge clk);
    #1;
    check("sync_held", 64'(delta(K_WR)), 64'd0);
    check("sync_busy", 64'(status_out[4]), 64'd1);
    syncing = 4'b0001;
    @(negedge clk);
    check("sync_strobe", 64'(block_reg_write), 64'b0010);
    repeat (3) @(posedge clk);
    #1;
    check("sync_once", 64'(delta(K_WR)), 64'd1);
    check("sync_fields", 64'({reg_target, data_out}),
          64'({4'h4, 16'h5566}));
    syncing = 4'b0000;

    // swap to pipeline 3 from active pipeline 0
    snap();
    send_byte(8'h63);
    @(negedge clk);
    check("swap_req", 64'({swap_pipelines, swap_target}),
          64'({1'b1, 2'd3}));
    check("swap_commit", 64'(reg_writes_commit), 64'b1000);
    @(posedge clk); #1;
    swapping = 1'b1;
    check("swap_en_both", 64'(pipeline_enables), 64'b1001);
    repeat (10) @(posedge clk);
    #1;
    check("swap_cur_hold", 64'(current_pipeline), 64'd0);
    swapping = 1'b0;
    resetting = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    check("swap_cur_new", 64'(current_pipeline), 64'd3);
    check("swap_en_new", 64'(pipeline_enables), 64'b1000);
    check("settle_busy", 64'(status_out[4]), 64'd1);
    resetting = 4'b0000;
    wait_idle("settle_idle");
    check("swap_status", 64'(status_out), 64'h03);
    check("swap_pulses", 64'(delta(K_SWAP)), 64'd1);

    // watchdog: command byte then stall in the block field
    snap();
    send_byte(8'h12);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!error_pulse && k < 200);
    // one DECODE cycle, then 100 stalled cycles
    check("wd_cycle", 64'(k), 64'd101);
    @(posedge clk); #1;
    check("wd_code", 64'(status_out[7:4]), 64'h6);
    check("wd_no_write", 64'(delta(K_INSTR)), 64'd0);
    snap();
    send_seq(56'h12_01_11_22_33_44_00, 6);
    repeat (3) @(posedge clk);
    #1;
    check("wd_after_cnt", 64'(delta(K_INSTR)), 64'd1);
    check("wd_after_mask", 64'(smask[K_INSTR]), 64'b0100);
    check("wd_after_instr", 64'(instr_out), 64'h11223344);
    check("wd_after_err", 64'(status_out[7:5]), 64'd0);

    // reset while the first delay byte is being taken
    snap();
    send_seq(56'h51_00_01_00_00_00_00, 3);
    @(posedge clk); #1;
    in_byte = 8'h00;
    in_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_byte4_taken", 64'(next), 64'd1);
    #2;
    reset = 1'b1;
    in_ready = 1'b0;
    #1;
    check("mid_next", 64'(next), 64'd0);
    check("mid_status", 64'(status_out), 64'd0);
    check("mid_en_cur",
          64'({pipeline_enables, current_pipeline}),
          64'({4'b0001, 2'd0}));
    check("mid_fields", 64'({data_out, buf_init_delay}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_alloc", 64'(delta(K_ALLOC)), 64'd0);
    snap();
    send_seq(56'h51_00_01_00_01_23_45, 7);
    repeat (3) @(posedge clk);
    #1;
    check("post_alloc_cnt", 64'(delta(K_ALLOC)), 64'd1);
    check("post_alloc_mask", 64'(smask[K_ALLOC]), 64'b0010);
    check("post_alloc_delay", 64'(buf_init_delay), 64'h00012345);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
